// File: rtl/serial_cmd_initiator.sv
// -----------------------------------------------------------------------------
// serial_cmd_initiator
//
// Sends a command (opcode byte followed by its argument bytes) over a UART
// transmitter and, for opcodes that expect a reply, collects the response
// bytes. Opcode 0 returns a single version byte. Opcode 4 returns 136 bytes,
// which are packed into 34 little-endian 32-bit words (32 histogram bins
// followed by 2 output counters). An inactivity timer aborts a reply that
// stalls for TIMEOUT_CYCLES clocks.
//
// Ports
//   clk, reset          : sole clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, cmd_ready high only when idle
//   cmd_op              : opcode (0-7 legal, 8-15 rejected with error 2)
//   cmd_args            : up to six argument bytes, arg0 in [7:0]
//   txBusy              : UART transmitter busy
//   txStart/txData      : one-cycle byte-send strobe and its byte
//   rxReady/rxData      : one-cycle received-byte strobe and its byte
//   word_valid          : one-cycle strobe for an assembled response word
//   word_data           : assembled word, first received byte in [7:0]
//   word_index          : number (0-33) of the word on word_data
//   resp_version        : last version byte received for opcode 0
//   done                : one-cycle completion strobe, also on errors
//   error               : status qualified by done (0 ok, 1 timeout, 2 bad op)
// -----------------------------------------------------------------------------
module serial_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [47:0] cmd_args,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        rxReady,
  input  logic [7:0]  rxData,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [5:0]  word_index,
  output logic [7:0]  resp_version,
  output logic        done,
  output logic [1:0]  error
);

  // The counter only needs to hold 0..TIMEOUT_CYCLES-1: the abort is taken
  // in the cycle where it would have stepped up to TIMEOUT_CYCLES.
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BAD_OP  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    TX_LOAD,
    TX_GAP,
    RECV,
    FINISH
  } state_t;

  // Number of argument bytes that follow the opcode byte.
  function automatic logic [2:0] arg_count(input logic [2:0] op);
    logic [2:0] n;
    case (op)
      3'd1:    n = 3'd1;
      3'd2:    n = 3'd6;
      3'd3:    n = 3'd1;
      3'd5:    n = 3'd1;
      3'd7:    n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Number of reply bytes the peer sends back for each opcode.
  function automatic logic [7:0] resp_len(input logic [2:0] op);
    logic [7:0] n;
    case (op)
      3'd0:    n = 8'd1;
      3'd4:    n = 8'd136;
      default: n = 8'd0;
    endcase
    return n;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [47:0]      args_q, args_d;
  logic [1:0]       err_q, err_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       rx_cnt_q, rx_cnt_d;
  logic [23:0]      partial_q, partial_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             word_valid_q, word_valid_d;
  logic [31:0]      word_data_q, word_data_d;
  logic [5:0]       word_index_q, word_index_d;
  logic [7:0]       resp_version_q, resp_version_d;

  logic             tx_start;
  logic [7:0]       tx_byte;
  logic [7:0]       next_byte;

  // Byte selected by the transmit index: index 0 is the opcode byte, index i
  // is argument byte i-1 of the latched argument vector.
  always_comb begin
    next_byte = 8'h00;
    case (tx_idx_q)
      3'd0:    next_byte = {5'b00000, op_q};
      3'd1:    next_byte = args_q[7:0];
      3'd2:    next_byte = args_q[15:8];
      3'd3:    next_byte = args_q[23:16];
      3'd4:    next_byte = args_q[31:24];
      3'd5:    next_byte = args_q[39:32];
      3'd6:    next_byte = args_q[47:40];
      default: next_byte = 8'h00;
    endcase
  end

  // Next-state and datapath logic. txStart is decoded combinationally from
  // the current state and txBusy so that it can never coincide with a busy
  // transmitter, even if txBusy rises without warning.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    args_d         = args_q;
    err_d          = err_q;
    tx_idx_d       = tx_idx_q;
    rx_cnt_d       = rx_cnt_q;
    partial_d      = partial_q;
    to_d           = to_q;
    word_valid_d   = 1'b0;
    word_data_d    = word_data_q;
    word_index_d   = word_index_q;
    resp_version_d = resp_version_q;
    tx_start       = 1'b0;
    tx_byte        = 8'h00;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op[2:0];
          args_d    = cmd_args;
          tx_idx_d  = 3'd0;
          rx_cnt_d  = 8'd0;
          partial_d = 24'd0;
          to_d      = '0;
          // Illegal opcodes skip transmission entirely; FINISH reports them.
          if (cmd_op[3]) begin
            err_d   = ERR_BAD_OP;
            state_d = FINISH;
          end else begin
            err_d   = ERR_OK;
            state_d = TX_LOAD;
          end
        end
      end

      TX_LOAD: begin
        if (!txBusy) begin
          tx_start = 1'b1;
          tx_byte  = next_byte;
          tx_idx_d = tx_idx_q + 3'd1;
          state_d  = TX_GAP;
        end
      end

      // One dead cycle after every strobe gives the transmitter time to
      // raise txBusy before the next byte is considered.
      TX_GAP: begin
        if (tx_idx_q <= arg_count(op_q)) begin
          state_d = TX_LOAD;
        end else if (resp_len(op_q) != 8'd0) begin
          to_d    = '0;
          state_d = RECV;
        end else begin
          state_d = FINISH;
        end
      end

      // A byte arriving in the same cycle as the timer would expire wins:
      // the rxReady branch is checked first and restarts the timer.
      RECV: begin
        if (rxReady) begin
          to_d     = '0;
          rx_cnt_d = rx_cnt_q + 8'd1;
          if (op_q == 3'd0) begin
            resp_version_d = rxData;
          end else begin
            partial_d = {rxData, partial_q[23:8]};
            if (rx_cnt_q[1:0] == 2'd3) begin
              word_valid_d = 1'b1;
              word_data_d  = {rxData, partial_q};
              word_index_d = rx_cnt_q[7:2];
            end
          end
          if (rx_cnt_q == 8'(resp_len(op_q) - 8'd1)) begin
            state_d = FINISH;
          end
        end else if (to_q == TO_LAST) begin
          err_d     = ERR_TIMEOUT;
          partial_d = 24'd0;
          state_d   = FINISH;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= 3'd0;
      args_q         <= 48'd0;
      err_q          <= ERR_OK;
      tx_idx_q       <= 3'd0;
      rx_cnt_q       <= 8'd0;
      partial_q      <= 24'd0;
      to_q           <= '0;
      word_valid_q   <= 1'b0;
      word_data_q    <= 32'd0;
      word_index_q   <= 6'd0;
      resp_version_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      args_q         <= args_d;
      err_q          <= err_d;
      tx_idx_q       <= tx_idx_d;
      rx_cnt_q       <= rx_cnt_d;
      partial_q      <= partial_d;
      to_q           <= to_d;
      word_valid_q   <= word_valid_d;
      word_data_q    <= word_data_d;
      word_index_q   <= word_index_d;
      resp_version_q <= resp_version_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign txStart      = tx_start;
  assign txData       = tx_byte;
  assign word_valid   = word_valid_q;
  assign word_data    = word_data_q;
  assign word_index   = word_index_q;
  assign resp_version = resp_version_q;
  assign done         = (state_q == FINISH);
  // The status is only meaningful alongside done, so it reads zero otherwise.
  assign error        = done ? err_q : ERR_OK;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_serial_cmd_initiator
//
// Self-checking bench for serial_cmd_initiator. A small UART emulation drives
// txBusy after each strobe, a monitor logs every strobe, word and completion,
// and each test task compares the logs against expectations built from the
// opcode tables and byte-packing rules of the command protocol.
// -----------------------------------------------------------------------------
module tb_serial_cmd_initiator;

  localparam int TIMEOUT = 100;
  localparam int NARGS [8] = '{0, 1, 6, 1, 0, 1, 0, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [47:0] cmd_args;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic        rxReady;
  logic [7:0]  rxData;
  logic        word_valid;
  logic [31:0] word_data;
  logic [5:0]  word_index;
  logic [7:0]  resp_version;
  logic        done;
  logic [1:0]  error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  tx_q [$];
  logic [31:0] w_q [$];
  int          wi_q [$];
  int          wc_q [$];
  int          done_cnt  = 0;
  int          busy_viol = 0;

  int busy_len   = 0;
  bit busy_noise = 1'b0;
  int busy_left  = 0;

  serial_cmd_initiator #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_args     (cmd_args),
    .txBusy       (txBusy),
    .txStart      (txStart),
    .txData       (txData),
    .rxReady      (rxReady),
    .rxData       (rxData),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_index   (word_index),
    .resp_version (resp_version),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Cycle number; stable when sampled on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Logs everything the DUT emits, sampled mid-cycle.
  always @(negedge clk) begin
    if (txStart === 1'b1) begin
      tx_q.push_back(txData);
      if (txBusy === 1'b1) busy_viol++;
    end
    if (word_valid === 1'b1) begin
      w_q.push_back(word_data);
      wi_q.push_back(int'(word_index));
      wc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Transmitter emulation: busy for busy_len cycles after each strobe,
  // optionally with random extra busy cycles in between.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (txStart === 1'b1) busy_left = busy_len;
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
        txBusy = 1'b1;
        busy_left--;
      end else begin
        txBusy = busy_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic clear_logs();
    tx_q.delete();
    w_q.delete();
    wi_q.delete();
    wc_q.delete();
    busy_viol = 0;
  endtask

  // Presents a command and returns the cycle in which it was accepted; the
  // command inputs are scrambled afterwards to expose missing latching.
  task automatic issue_cmd(input logic [3:0] op, input logic [47:0] args,
                           output int acc_cyc, output bit ok);
    ok = 1'b0;
    acc_cyc = -1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_args = args;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom);
    cmd_args = {16'($urandom), 32'($urandom)};
  endtask

  task automatic wait_tx(input int n, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits `idle` cycles, then pulses rxReady for one cycle; rc is that cycle.
  task automatic send_rx(input logic [7:0] b, input int idle, output int rc);
    idle_cycles(idle);
    rxReady = 1'b1;
    rxData = b;
    @(negedge clk);
    rc = cyc;
    @(posedge clk);
    #1;
    rxReady = 1'b0;
    rxData = 8'($urandom);
  endtask

  // Waits for done; reports its status, its cycle and cmd_ready in the done
  // cycle and in the cycle after.
  task automatic wait_done(input int max_cycles, output bit ok, output logic [1:0] err,
                           output int dcyc, output logic rdy_at, output logic rdy_after);
    ok = 1'b0;
    err = 2'bxx;
    dcyc = -1;
    rdy_at = 1'bx;
    rdy_after = 1'bx;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        err = error;
        dcyc = cyc;
        rdy_at = cmd_ready;
        break;
      end
    end
    if (ok) begin
      @(negedge clk);
      rdy_after = cmd_ready;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    cmd_args = 48'd0;
    rxReady = 1'b0;
    rxData = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({txStart, done, word_valid, error} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold_outputs: got txStart=%b done=%b word_valid=%b error=%0d required all zero",
               txStart, done, word_valid, error);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
    n_checks++;
    if ({txData, word_data, word_index, resp_version} !== 54'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got txData=%h word_data=%h word_index=%0d resp_version=%h required zero",
               txData, word_data, word_index, resp_version);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_version_read();
    bit ok;
    int acc, rc, dcyc;
    logic [1:0] err;
    logic rdy_at, rdy_after;
    logic [7:0] reply;
    busy_len = 0;
    busy_noise = 1'b0;
    // A byte outside a reply phase must be dropped.
    send_rx(8'hAA, 1, rc);
    idle_cycles(2);
    n_checks++;
    if (resp_version !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL idle_rx_ignored: got resp_version=%h required 00", resp_version);
    end
    for (int it = 0; it < 3; it++) begin
      reply = (it == 0) ? 8'h17 : 8'($urandom);
      clear_logs();
      issue_cmd(4'd0, {16'($urandom), 32'($urandom)}, acc, ok);
      wait_tx(1, 50, ok);
      idle_cycles(3);
      send_rx(reply, 0, rc);
      wait_done(20, ok, err, dcyc, rdy_at, rdy_after);
      n_checks++;
      if (!ok || err !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL op0_done: got seen=%0d error=%0d required seen=1 error=0", ok, err);
      end
      n_checks++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL op0_tx: got %0d strobes first=%h required 1 strobe of 00",
                 tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
      end
      n_checks++;
      if (resp_version !== reply) begin
        n_fail++;
        $display("[TB] FAIL op0_version: got %h required %h", resp_version, reply);
      end
    end
  endtask

  task automatic test_bad_opcode();
    bit ok, ok2;
    int acc, dcyc;
    logic [1:0] err;
    logic rdy_at, rdy_after;
    logic [3:0] op;
    for (int it = 0; it < 4; it++) begin
      op = (it == 0) ? 4'd9 : 4'($urandom_range(8, 15));
      clear_logs();
      issue_cmd(op, {16'($urandom), 32'($urandom)}, acc, ok);
      wait_done(20, ok2, err, dcyc, rdy_at, rdy_after);
      idle_cycles(3);
      n_checks++;
      if (!ok || !ok2 || dcyc != acc + 1 || err !== 2'd2) begin
        n_fail++;
        $display("[TB] FAIL bad_op_done op=%0d: got done_cycle=%0d error=%0d required done_cycle=%0d error=2",
                 op, dcyc, err, acc + 1);
      end
      n_checks++;
      if (tx_q.size() != 0) begin
        n_fail++;
        $display("[TB] FAIL bad_op_no_tx op=%0d: got %0d strobes required 0", op, tx_q.size());
      end
      n_checks++;
      if (rdy_after !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL bad_op_ready op=%0d: got cmd_ready=%b after done required 1", op, rdy_after);
      end
    end
  endtask

  task automatic test_tx_sequences();
    bit ok, ok2;
    int acc, dcyc;
    logic [1:0] err;
    logic rdy_at, rdy_after;
    logic [3:0] op;
    logic [47:0] args;
    logic [7:0] exp_q [$];
    int ops [6] = '{1, 2, 3, 5, 6, 7};
    for (int it = 0; it < 14; it++) begin
      if (it == 0) begin
        op = 4'd2;
        args = 48'h060504030201;
        busy_len = 3;
        busy_noise = 1'b0;
      end else begin
        op = 4'(ops[$urandom_range(0, 5)]);
        args = {16'($urandom), 32'($urandom)};
        busy_len = $urandom_range(0, 4);
        busy_noise = 1'($urandom_range(0, 1));
      end
      exp_q.delete();
      exp_q.push_back({4'b0000, op});
      for (int i = 0; i < NARGS[op[2:0]]; i++) exp_q.push_back(args[8*i +: 8]);
      clear_logs();
      issue_cmd(op, args, acc, ok);
      wait_done(2000, ok2, err, dcyc, rdy_at, rdy_after);
      n_checks++;
      if (!ok || !ok2 || err !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL tx_done op=%0d: got seen=%0d error=%0d required seen=1 error=0", op, ok2, err);
      end
      n_checks++;
      if (tx_q.size() != exp_q.size()) begin
        n_fail++;
        $display("[TB] FAIL tx_count op=%0d: got %0d strobes required %0d", op, tx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("[TB] FAIL tx_byte op=%0d idx=%0d: got %h required %h",
                   op, i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
        end
      end
      n_checks++;
      if (busy_viol != 0) begin
        n_fail++;
        $display("[TB] FAIL tx_while_busy op=%0d: got %0d strobes during txBusy required 0", op, busy_viol);
      end
      n_checks++;
      if (rdy_at !== 1'b0 || rdy_after !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL ready_after_done op=%0d: got %b then %b required 0 then 1", op, rdy_at, rdy_after);
      end
    end
    busy_len = 0;
    busy_noise = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int acc, dcyc, idle;
    logic [1:0] err;
    logic rdy_at, rdy_after;
    logic [7:0] b [10];
    int rcs [10];
    logic [31:0] exp_w;
    busy_len = 1;
    clear_logs();
    for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
    issue_cmd(4'd4, {16'($urandom), 32'($urandom)}, acc, ok);
    wait_tx(1, 50, ok);
    idle_cycles(3);
    for (int i = 0; i < 10; i++) begin
      // Byte 6 lands exactly in the cycle the timer would expire.
      idle = (i == 6) ? TIMEOUT - 1 : $urandom_range(0, 3);
      send_rx(b[i], idle, rcs[i]);
    end
    wait_done(TIMEOUT + 20, ok, err, dcyc, rdy_at, rdy_after);
    n_checks++;
    if (!ok || err !== 2'd1 || dcyc != rcs[9] + TIMEOUT + 1) begin
      n_fail++;
      $display("[TB] FAIL timeout_done: got seen=%0d error=%0d cycle=%0d required error=1 cycle=%0d",
               ok, err, dcyc, rcs[9] + TIMEOUT + 1);
    end
    n_checks++;
    if (w_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL timeout_word_count: got %0d required 2", w_q.size());
    end
    for (int k = 0; k < 2; k++) begin
      exp_w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      n_checks++;
      if (k >= w_q.size() || w_q[k] !== exp_w || wi_q[k] != k) begin
        n_fail++;
        $display("[TB] FAIL timeout_word %0d: got %h index %0d required %h index %0d",
                 k, (k < w_q.size()) ? w_q[k] : 32'hx, (k < wi_q.size()) ? wi_q[k] : -1, exp_w, k);
      end
    end
    n_checks++;
    if (wc_q.size() < 2 || wc_q[1] != rcs[7] + 1) begin
      n_fail++;
      $display("[TB] FAIL word_valid_latency: got cycle %0d required %0d",
               (wc_q.size() > 1) ? wc_q[1] : -1, rcs[7] + 1);
    end
    busy_len = 0;
  endtask

  task automatic test_histogram(input bit random_data);
    bit ok;
    int acc, dcyc, rc;
    logic [1:0] err;
    logic rdy_at, rdy_after;
    logic [7:0] b [136];
    logic [31:0] exp_w, got_w;
    for (int n = 0; n < 136; n++) b[n] = random_data ? 8'($urandom) : 8'(n);
    clear_logs();
    issue_cmd(4'd4, {16'($urandom), 32'($urandom)}, acc, ok);
    wait_tx(1, 50, ok);
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h04) begin
      n_fail++;
      $display("[TB] FAIL op4_tx: got %0d strobes first=%h required 1 strobe of 04",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    idle_cycles(3);
    rc = 0;
    for (int n = 0; n < 136; n++) send_rx(b[n], $urandom_range(0, 2), rc);
    wait_done(20, ok, err, dcyc, rdy_at, rdy_after);
    n_checks++;
    if (!ok || err !== 2'd0 || rdy_after !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL op4_done: got seen=%0d error=%0d ready_after=%b required 1, 0, 1", ok, err, rdy_after);
    end
    n_checks++;
    if (w_q.size() != 34) begin
      n_fail++;
      $display("[TB] FAIL op4_word_count: got %0d required 34", w_q.size());
    end
    for (int k = 0; k < 34; k++) begin
      exp_w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      got_w = (k < w_q.size()) ? w_q[k] : 32'hxxxxxxxx;
      n_checks++;
      if (got_w !== exp_w || k >= wi_q.size() || wi_q[k] != k) begin
        n_fail++;
        $display("[TB] FAIL op4_word %0d: got %h index %0d required %h index %0d",
                 k, got_w, (k < wi_q.size()) ? wi_q[k] : -1, exp_w, k);
      end
    end
    if (!random_data) begin
      n_checks++;
      if (w_q.size() != 34 || w_q[0] !== 32'h03020100 || w_q[33] !== 32'h87868584) begin
        n_fail++;
        $display("[TB] FAIL op4_known_words: got %h / %h required 03020100 / 87868584",
                 (w_q.size() > 0) ? w_q[0] : 32'hx, (w_q.size() == 34) ? w_q[33] : 32'hx);
      end
    end
    n_checks++;
    if (wc_q.size() != 34 || wc_q[33] != rc + 1) begin
      n_fail++;
      $display("[TB] FAIL op4_last_word_cycle: got %0d required %0d",
               (wc_q.size() == 34) ? wc_q[33] : -1, rc + 1);
    end
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    int acc, dc_before;
    clear_logs();
    busy_len = 3;
    issue_cmd(4'd2, 48'h060504030201, acc, ok);
    wait_tx(3, 200, ok);
    dc_before = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (txStart !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_txstart: got %b required 0", txStart);
    end
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(30);
    n_checks++;
    if (!ok || tx_q.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_strobes: got %0d strobes required 3", tx_q.size());
    end
    n_checks++;
    if (cmd_ready !== 1'b1 || done_cnt != dc_before) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_idle: got cmd_ready=%b done pulses=%0d required 1 and 0",
               cmd_ready, done_cnt - dc_before);
    end
    n_checks++;
    if ({resp_version, word_data, word_index} !== 46'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_values: got resp_version=%h word_data=%h word_index=%0d required zero",
               resp_version, word_data, word_index);
    end
    busy_len = 0;
  endtask

  // Hang guard: every wait is bounded, this only trips on a simulator stall.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion required finish within 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_version_read();
    test_bad_opcode();
    test_tx_sequences();
    test_timeout();
    test_histogram(1'b0);
    test_histogram(1'b1);
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
